rsqrt_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-point Goldschmidt square-root / reciprocal-square-root pipeline among N requesters. Each requester may have at most one operation in flight. A tag shift register, aligned with the pipeline latency, routes every result back to the requester that issued it. The block sits between the ray-tracer units that need normalisation (sqrt / rsqrt) and the single shared `goldschmidt` instance, which it drives directly.

---
 rtl/rsqrt_arbiter_if.sv | 45 ++++
 rtl/rsqrt_arbiter.sv | 142 ++++++++++++++
 tb/tb_rsqrt_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsqrt_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | rsqrt_arbiter_if                                                         |
// | Bundles the requester side and the Goldschmidt pipeline side of the      |
// | shared sqrt/rsqrt arbiter.                                               |
// |   slave  : arbiter view (requests, result consumption, pipeline results  |
// |            in; grants, held results, pipeline issue, status out)        |
// |   master : environment view (requesters plus the pipeline)              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface rsqrt_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_in;
  logic [N*W-1:0] req_est;
  logic [N-1:0]   res_valid;
  logic [N-1:0]   res_ready;
  logic [N*W-1:0] res_sqrt;
  logic [N*W-1:0] res_rsqrt;
  logic           gs_start;
  logic [W-1:0]   gs_in;
  logic [W-1:0]   gs_est;
  logic           gs_valid;
  logic [W-1:0]   gs_sqrt;
  logic [W-1:0]   gs_rsqrt;
  logic [N-1:0]   inflight;
  logic           tag_err;

  modport slave (
    input  req_valid, req_in, req_est, res_ready, gs_valid, gs_sqrt, gs_rsqrt,
    output req_ready, res_valid, res_sqrt, res_rsqrt, gs_start, gs_in, gs_est,
           inflight, tag_err
  );

  modport master (
    output req_valid, req_in, req_est, res_ready, gs_valid, gs_sqrt, gs_rsqrt,
    input  req_ready, res_valid, res_sqrt, res_rsqrt, gs_start, gs_in, gs_est,
           inflight, tag_err
  );
endinterface
`default_nettype wire

// File: rtl/rsqrt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | rsqrt_arbiter                                                            |
// | Round-robin arbiter sharing one Goldschmidt sqrt/rsqrt pipeline among N  |
// | requesters, one operation in flight per requester. A tag shift register  |
// | matched to the pipeline latency returns each result to its issuer.       |
// | Ports:                                                                   |
// |   clk     : clock                                                        |
// |   resetn  : asynchronous active-low reset (shared with the pipeline)     |
// |   bus     : rsqrt_arbiter_if.slave (requester handshakes, held results, |
// |             pipeline issue/return, inflight flags, sticky tag_err)       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module rsqrt_arbiter #(
  parameter int N   = 4,
  parameter int IW  = 8,
  parameter int QW  = 24,
  parameter int LAT = 4
) (
  input  wire logic      clk,
  input  wire logic      resetn,
  rsqrt_arbiter_if.slave bus
);
  localparam int c_W   = IW + QW;
  localparam int c_IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     r_busy;
  logic [N-1:0]     r_res_valid;
  logic [c_IDW-1:0] r_ptr;
  logic [N*c_W-1:0] r_res_sqrt;
  logic [N*c_W-1:0] r_res_rsqrt;
  logic [LAT-1:0]   r_tag_v;
  logic [c_IDW-1:0] r_tag_id [LAT];
  logic             r_tag_err;

  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_grant;
  logic [c_IDW-1:0] w_gnt_id;
  logic             w_gnt_any;
  logic [c_W-1:0]   w_gs_in;
  logic [c_W-1:0]   w_gs_est;
  logic [N-1:0]     w_res_hs;
  logic [N-1:0]     w_cap;
  logic             w_tail_v;
  logic [c_IDW-1:0] w_tail_id;

  // Round-robin search starting just after the last granted index. Busy
  // requesters are skipped, so a requester whose result is being consumed
  // this cycle is still ineligible; that also keeps res_ready out of the
  // grant path.
  always_comb begin
    logic [c_IDW-1:0] idx;
    idx       = '0;
    w_elig    = bus.req_valid & ~r_busy;
    w_grant   = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = c_IDW'((int'(r_ptr) + k) % N);
      if (resetn && !w_gnt_any && w_elig[idx]) begin
        w_gnt_any     = 1'b1;
        w_gnt_id      = idx;
        w_grant[idx]  = 1'b1;
      end
    end
  end

  // Operand mux: zero when nothing is granted.
  always_comb begin
    w_gs_in  = '0;
    w_gs_est = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gs_in  = bus.req_in[i*c_W +: c_W];
        w_gs_est = bus.req_est[i*c_W +: c_W];
      end
    end
  end

  assign w_res_hs  = r_res_valid & bus.res_ready;
  assign w_tail_v  = r_tag_v[LAT-1];
  assign w_tail_id = r_tag_id[LAT-1];

  // A pipeline result is only accepted when the tag pipe agrees it is due.
  always_comb begin
    w_cap = '0;
    for (int i = 0; i < N; i++) begin
      w_cap[i] = w_tail_v && bus.gs_valid && (w_tail_id == c_IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy      <= '0;
      r_res_valid <= '0;
      r_ptr       <= c_IDW'(N - 1);
      r_res_sqrt  <= '0;
      r_res_rsqrt <= '0;
      r_tag_v     <= '0;
      r_tag_err   <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      // Set and clear never hit the same requester in one cycle: a grant
      // needs ~busy, a result handshake needs res_valid which implies busy.
      r_busy      <= (r_busy | w_grant) & ~w_res_hs;
      r_res_valid <= (r_res_valid & ~w_res_hs) | w_cap;
      if (w_gnt_any) begin
        r_ptr <= w_gnt_id;
      end
      for (int i = 0; i < N; i++) begin
        if (w_cap[i]) begin
          r_res_sqrt[i*c_W +: c_W]  <= bus.gs_sqrt;
          r_res_rsqrt[i*c_W +: c_W] <= bus.gs_rsqrt;
        end
      end
      r_tag_v[0]  <= w_gnt_any;
      r_tag_id[0] <= w_gnt_id;
      for (int s = 1; s < LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      if (w_tail_v != bus.gs_valid) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.gs_start  = w_gnt_any;
  assign bus.gs_in     = w_gs_in;
  assign bus.gs_est    = w_gs_est;
  assign bus.res_valid = r_res_valid;
  assign bus.res_sqrt  = r_res_sqrt;
  assign bus.res_rsqrt = r_res_rsqrt;
  assign bus.inflight  = r_busy;
  assign bus.tag_err   = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_rsqrt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_rsqrt_arbiter                                                         |
// | Self-checking bench for rsqrt_arbiter with a pass-through stub pipeline  |
// | (sqrt = S, rsqrt = y0, delayed LAT cycles) and a transaction-level       |
// | reference model of grants, in-flight operations and held results.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rsqrt_arbiter;
  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int QW  = 24;
  localparam int W   = IW + QW;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rsqrt_arbiter_if #(.N(N), .W(W)) bus ();

  rsqrt_arbiter #(.N(N), .IW(IW), .QW(QW), .LAT(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // Stub pipeline sharing resetn; spur injects a gs_valid with no tag.
  logic [LAT-1:0] st_v;
  logic [W-1:0]   st_in  [LAT];
  logic [W-1:0]   st_est [LAT];
  logic           spur;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_v <= '0;
      for (int s = 0; s < LAT; s++) begin
        st_in[s]  <= '0;
        st_est[s] <= '0;
      end
    end else begin
      st_v[0]   <= bus.gs_start;
      st_in[0]  <= bus.gs_in;
      st_est[0] <= bus.gs_est;
      for (int s = 1; s < LAT; s++) begin
        st_v[s]   <= st_v[s-1];
        st_in[s]  <= st_in[s-1];
        st_est[s] <= st_est[s-1];
      end
    end
  end

  assign bus.gs_valid = st_v[LAT-1] | spur;
  assign bus.gs_sqrt  = st_in[LAT-1];
  assign bus.gs_rsqrt = st_est[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (operation level) ----------------
  typedef struct {
    int           id;
    logic [W-1:0] s;
    logic [W-1:0] e;
    int           due;
  } op_t;

  op_t          m_q[$];
  logic [N-1:0] m_busy;
  logic [N-1:0] m_rv;
  logic [W-1:0] m_sqrt  [N];
  logic [W-1:0] m_rsqrt [N];
  logic         m_terr;
  int           m_ptr;
  int           e_g;
  int           cyc = 0;

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_rv   = '0;
    m_terr = 1'b0;
    m_ptr  = N - 1;
    e_g    = -1;
    for (int i = 0; i < N; i++) begin
      m_sqrt[i]  = '0;
      m_rsqrt[i] = '0;
    end
  endtask

  // Compare every DUT output against the model at the falling edge.
  task automatic sample();
    logic [N-1:0] er;
    logic [W-1:0] ein;
    logic [W-1:0] eest;
    @(negedge clk);
    if (!resetn) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_gs_start", bus.gs_start, 0);
      chk("rst_gs_in", bus.gs_in, 0);
      chk("rst_gs_est", bus.gs_est, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_sqrt", bus.res_sqrt, 0);
      chk("rst_res_rsqrt", bus.res_rsqrt, 0);
      chk("rst_inflight", bus.inflight, 0);
      chk("rst_tag_err", bus.tag_err, 0);
      model_reset();
      return;
    end
    e_g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (e_g < 0 && bus.req_valid[j] && !m_busy[j]) e_g = j;
    end
    er   = '0;
    ein  = '0;
    eest = '0;
    if (e_g >= 0) begin
      er[e_g] = 1'b1;
      ein     = bus.req_in[e_g*W +: W];
      eest    = bus.req_est[e_g*W +: W];
    end
    chk("req_ready", bus.req_ready, er);
    chk("gs_start", bus.gs_start, (e_g >= 0));
    chk("gs_in", bus.gs_in, ein);
    chk("gs_est", bus.gs_est, eest);
    chk("res_valid", bus.res_valid, m_rv);
    chk("inflight", bus.inflight, m_busy);
    chk("tag_err", bus.tag_err, m_terr);
    for (int i = 0; i < N; i++) begin
      if (m_rv[i]) begin
        chk("res_sqrt", bus.res_sqrt[i*W +: W], m_sqrt[i]);
        chk("res_rsqrt", bus.res_rsqrt[i*W +: W], m_rsqrt[i]);
      end
    end
  endtask

  // Apply what happens at the next rising edge, then step past it.
  task automatic advance();
    logic [N-1:0] hs;
    bit           due_now;
    if (resetn) begin
      due_now = 0;
      hs      = m_rv & bus.res_ready;
      m_rv    = m_rv & ~hs;
      m_busy  = m_busy & ~hs;
      for (int k = m_q.size() - 1; k >= 0; k--) begin
        if (m_q[k].due == cyc) begin
          due_now             = 1;
          m_rv[m_q[k].id]     = 1'b1;
          m_sqrt[m_q[k].id]   = m_q[k].s;
          m_rsqrt[m_q[k].id]  = m_q[k].e;
          m_q.delete(k);
        end
      end
      if (spur && !due_now) m_terr = 1'b1;
      if (e_g >= 0) begin
        m_busy[e_g] = 1'b1;
        m_ptr       = e_g;
        m_q.push_back('{e_g, bus.req_in[e_g*W +: W], bus.req_est[e_g*W +: W], cyc + LAT});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.res_ready = '0;
    bus.req_in    = '0;
    bus.req_est   = '0;
    spur          = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    sample(); advance();
    sample(); advance();
    resetn = 1'b1;
  endtask

  // ---------------- table for all-requesters-at-once ----------------
  typedef struct {
    logic [N-1:0] req_valid;
    logic [N-1:0] res_ready;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_res_valid;
    logic [N-1:0] exp_inflight;
    logic [W-1:0] exp_gs_in;
  } vec_t;

  vec_t tbl [12];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int issues, same, grants, prev, hs_cyc, re_cyc;
    bit held_ok, seen_rv;
    logic [W-1:0] held;

    tbl[0]  = '{4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 32'd1};
    tbl[1]  = '{4'hF, 4'hF, 4'h2, 4'h0, 4'h1, 32'd2};
    tbl[2]  = '{4'hF, 4'hF, 4'h4, 4'h0, 4'h3, 32'd3};
    tbl[3]  = '{4'hF, 4'hF, 4'h8, 4'h0, 4'h7, 32'd4};
    tbl[4]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 32'd0};
    tbl[5]  = '{4'hF, 4'hF, 4'h0, 4'h1, 4'hF, 32'd0};
    tbl[6]  = '{4'hF, 4'hF, 4'h1, 4'h2, 4'hE, 32'd1};
    tbl[7]  = '{4'hF, 4'hF, 4'h2, 4'h4, 4'hD, 32'd2};
    tbl[8]  = '{4'hF, 4'hF, 4'h4, 4'h8, 4'hB, 32'd3};
    tbl[9]  = '{4'hF, 4'hF, 4'h8, 4'h0, 4'h7, 32'd4};
    tbl[10] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 32'd0};
    tbl[11] = '{4'hF, 4'hF, 4'h0, 4'h1, 4'hF, 32'd0};

    idle();
    model_reset();
    do_reset();

    // Single request in cycle 2, result consumed in cycle 7.
    for (int t = 0; t < 11; t++) begin
      bus.req_valid         = (t == 2) ? 4'h1 : 4'h0;
      bus.req_in[W-1:0]     = 32'h0400_0000;
      bus.req_est[W-1:0]    = 32'h0080_0000;
      bus.res_ready         = (t == 7) ? 4'h1 : 4'h0;
      sample();
      if (t == 2) chk("s1_gs_start", bus.gs_start, 1);
      chk("s1_inflight0", bus.inflight[0], (t >= 3 && t <= 7));
      chk("s1_res_valid0", bus.res_valid[0], (t == 7));
      if (t == 7) begin
        chk("s1_sqrt", bus.res_sqrt[W-1:0], 32'h0400_0000);
        chk("s1_rsqrt", bus.res_rsqrt[W-1:0], 32'h0080_0000);
      end
      advance();
    end

    // All requesters at once, table driven.
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_in[i*W +: W]  = W'(i + 1);
      bus.req_est[i*W +: W] = W'((i + 1) << 8);
    end
    for (int t = 0; t < 12; t++) begin
      bus.req_valid = tbl[t].req_valid;
      bus.res_ready = tbl[t].res_ready;
      sample();
      chk("tbl_req_ready", bus.req_ready, tbl[t].exp_ready);
      chk("tbl_res_valid", bus.res_valid, tbl[t].exp_res_valid);
      chk("tbl_inflight", bus.inflight, tbl[t].exp_inflight);
      chk("tbl_gs_in", bus.gs_in, tbl[t].exp_gs_in);
      chk("tbl_gs_est", bus.gs_est, tbl[t].exp_gs_in << 8);
      for (int i = 0; i < N; i++) begin
        if (tbl[t].exp_res_valid[i]) chk("tbl_res_sqrt", bus.res_sqrt[i*W +: W], W'(i + 1));
      end
      advance();
    end

    // Fairness between two always-valid requesters.
    do_reset();
    bus.req_valid = 4'h3;
    bus.res_ready = 4'h3;
    bus.req_in    = {$urandom, $urandom, $urandom, $urandom};
    prev = -1; same = 0; grants = 0;
    for (int t = 0; t < 40; t++) begin
      sample();
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i]) begin
          if (i == prev) same++;
          prev = i;
          grants++;
        end
      end
      advance();
    end
    chk("fair_repeat", same, 0);
    chk("fair_grants_seen", (grants >= 8), 1);

    // Backpressure on requester 2.
    do_reset();
    bus.req_valid = 4'h4;
    bus.req_in[2*W +: W]  = 32'h1234_5678;
    bus.req_est[2*W +: W] = 32'h0ABC_DEF0;
    issues = 0; held_ok = 1; seen_rv = 0; held = '0;
    for (int t = 0; t < 20; t++) begin
      sample();
      if (bus.req_ready[2]) issues++;
      if (bus.res_valid[2]) begin
        if (seen_rv && bus.res_sqrt[2*W +: W] !== held) held_ok = 0;
        held    = bus.res_sqrt[2*W +: W];
        seen_rv = 1;
      end
      advance();
    end
    chk("bp_single_issue", issues, 1);
    chk("bp_held_stable", held_ok && seen_rv, 1);
    chk("bp_held_value", held, 32'h1234_5678);
    hs_cyc = cyc; re_cyc = -1;
    for (int t = 0; t < 4; t++) begin
      bus.res_ready = (t == 0) ? 4'h4 : 4'h0;
      sample();
      if (t == 0) chk("bp_no_reissue_in_hs_cycle", bus.req_ready[2], 0);
      if (bus.req_ready[2] && re_cyc < 0) re_cyc = cyc;
      advance();
    end
    chk("bp_reissued_after_hs", (re_cyc > hs_cyc) && (re_cyc <= hs_cyc + 2), 1);

    // Reset two cycles after an accept drops the operation.
    do_reset();
    bus.req_valid = 4'h2;
    sample(); advance();
    bus.req_valid = 4'h0;
    sample(); advance();
    resetn = 1'b0;
    sample(); advance();
    resetn = 1'b1;
    bus.res_ready = 4'hF;
    seen_rv = 0;
    for (int t = 0; t < 10; t++) begin
      sample();
      if (bus.res_valid != 0) seen_rv = 1;
      advance();
    end
    chk("rst_drop_no_res", seen_rv, 0);
    chk("rst_drop_inflight", bus.inflight, 0);

    // Spurious gs_valid with no tag sets a sticky tag_err.
    idle();
    spur = 1'b1;
    sample(); advance();
    spur = 1'b0;
    for (int t = 0; t < 5; t++) begin
      sample();
      chk("tag_err_sticky", bus.tag_err, 1);
      advance();
    end

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      bus.req_valid = (t % 500 < 100) ? 4'hF : N'($urandom);
      for (int i = 0; i < N; i++) bus.res_ready[i] = ($urandom_range(0, 3) != 0);
      bus.req_in  = {$urandom, $urandom, $urandom, $urandom};
      bus.req_est = {$urandom, $urandom, $urandom, $urandom};
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
